// File: rtl/delay_seq_pkg.sv
// Shared state encodings and sizing helpers for the channel release sequencer.
package delay_seq_pkg;

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_COUNT = 2'd1;
  localparam logic [1:0] ST_DONE  = 2'd2;

  typedef logic [1:0] state_t;

  // Channel index needs at least one bit even for a single channel.
  function automatic int ch_width(int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/delay_seq_counter.sv
// Up-counter with clear/enable that flags when it reaches the loaded terminal value
// and wraps to zero on the enabled cycle where the flag is set.
module seq_counter #(
  parameter int W = 8
) (
  input  logic         clk_i,
  input  logic         rst_i,
  input  logic         clr_i,
  input  logic         en_i,
  input  logic [W-1:0] term_val_i,
  output logic         term_o
);

  logic [W-1:0] r_cnt;

  assign term_o = (r_cnt == term_val_i);

  always_ff @(posedge clk_i) begin
    if (rst_i || clr_i) begin
      r_cnt <= '0;
    end else if (en_i) begin
      r_cnt <= term_o ? '0 : r_cnt + W'(1);
    end
  end

endmodule

// File: rtl/delay_seq.sv
// Releases NUM_CH sticky outputs in order, each after its own latched delay,
// then reports completion until the next start or reset.
//
//   state    | meaning
//   ST_IDLE  | waiting for start, nothing released
//   ST_COUNT | timing the delay of channel r_ch
//   ST_DONE  | all channels released, waiting for restart
module delay_seq
  import delay_seq_pkg::*;
#(
  parameter int NUM_CH  = 4,
  parameter int DELAY_W = 8
) (
  input  logic                      clk_i,
  input  logic                      rst_i,
  input  logic                      start_i,
  input  logic                      hold_i,
  input  logic [NUM_CH*DELAY_W-1:0] delay_i,
  output logic [NUM_CH-1:0]         release_o,
  output logic                      busy_o,
  output logic                      done_o
);

  localparam int CH_W = ch_width(NUM_CH);

  state_t                    r_state;
  logic [CH_W-1:0]           r_ch;
  logic [NUM_CH*DELAY_W-1:0] r_dly_q;
  logic [NUM_CH-1:0]         r_release;

  logic                      w_start_ok;
  logic                      w_count_en;
  logic                      w_term;
  logic                      w_last_ch;
  logic [DELAY_W-1:0]        w_dly_sel;
  logic [NUM_CH-1:0]         w_ch_sel;

  assign w_start_ok = start_i && ((r_state == ST_IDLE) || (r_state == ST_DONE));
  assign w_count_en = (r_state == ST_COUNT) && !hold_i;
  assign w_last_ch  = (r_ch == CH_W'(NUM_CH - 1));

  // Explicit compare mux keeps the index legal for non-power-of-two channel counts.
  always_comb begin
    w_dly_sel = '0;
    w_ch_sel  = '0;
    for (int k = 0; k < NUM_CH; k++) begin
      if (r_ch == CH_W'(k)) begin
        w_dly_sel   = r_dly_q[k*DELAY_W +: DELAY_W];
        w_ch_sel[k] = 1'b1;
      end
    end
  end

  seq_counter #(
    .W (DELAY_W)
  ) u_seq_counter (
    .clk_i      (clk_i),
    .rst_i      (rst_i),
    .clr_i      (w_start_ok),
    .en_i       (w_count_en),
    .term_val_i (w_dly_sel),
    .term_o     (w_term)
  );

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_state   <= ST_IDLE;
      r_ch      <= '0;
      r_dly_q   <= '0;
      r_release <= '0;
    end else begin
      case (r_state)
        ST_IDLE, ST_DONE: begin
          if (start_i) begin
            r_dly_q   <= delay_i;
            r_ch      <= '0;
            r_release <= '0;
            r_state   <= ST_COUNT;
          end
        end
        ST_COUNT: begin
          if (!hold_i && w_term) begin
            r_release <= r_release | w_ch_sel;
            if (w_last_ch) begin
              r_state <= ST_DONE;
            end else begin
              r_ch <= r_ch + CH_W'(1);
            end
          end
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  assign release_o = r_release;
  assign busy_o    = (r_state == ST_COUNT);
  assign done_o    = (r_state == ST_DONE);

endmodule

// File: tb/tb_delay_seq.sv
// Directed bench for delay_seq: three configurations checked every cycle against
// a countdown model of the release schedule, plus literal timing pins.
module tb_delay_seq;

  typedef struct packed {
    logic [3:0][7:0] d;
    logic [3:0]      rel;
    logic            busy;
    logic            done;
    logic [2:0]      ch;
    logic [8:0]      rem;
  } mdl_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  int n_vec = 0;
  int n_err = 0;
  logic chk_on = 1'b0;

  logic rst_a = 1'b1, start_a = 1'b0, hold_a = 1'b0;
  logic rst_b = 1'b1, start_b = 1'b0, hold_b = 1'b0;
  logic rst_c = 1'b1, start_c = 1'b0, hold_c = 1'b0;
  logic [3:0][7:0] dv_a = '0, dv_b = '0, dv_c = '0;

  logic [31:0] delay_a;
  logic [15:0] delay_b;
  logic [7:0]  delay_c;
  logic [3:0]  rel_a, rel_b;
  logic [0:0]  rel_c;
  logic busy_a, done_a, busy_b, done_b, busy_c, done_c;

  assign delay_a = dv_a;
  assign delay_b = {dv_b[3][3:0], dv_b[2][3:0], dv_b[1][3:0], dv_b[0][3:0]};
  assign delay_c = dv_c[0];

  delay_seq #(.NUM_CH(4), .DELAY_W(8)) u_a (
    .clk_i(clk), .rst_i(rst_a), .start_i(start_a), .hold_i(hold_a), .delay_i(delay_a),
    .release_o(rel_a), .busy_o(busy_a), .done_o(done_a));

  delay_seq #(.NUM_CH(4), .DELAY_W(4)) u_b (
    .clk_i(clk), .rst_i(rst_b), .start_i(start_b), .hold_i(hold_b), .delay_i(delay_b),
    .release_o(rel_b), .busy_o(busy_b), .done_o(done_b));

  delay_seq #(.NUM_CH(1), .DELAY_W(8)) u_c (
    .clk_i(clk), .rst_i(rst_c), .start_i(start_c), .hold_i(hold_c), .delay_i(delay_c),
    .release_o(rel_c), .busy_o(busy_c), .done_o(done_c));

  // Model: remaining-cycles countdown per pending release, one step per clock edge.
  function automatic mdl_t mdl_step(mdl_t m, int nch, logic rst, logic start, logic hold,
                                    logic [3:0][7:0] din);
    mdl_t n = m;
    if (rst) begin
      n = '0;
    end else if (!m.busy) begin
      if (start) begin
        n.d    = din;
        n.rel  = '0;
        n.busy = 1'b1;
        n.done = 1'b0;
        n.ch   = '0;
        n.rem  = 9'(din[0]) + 9'd1;
      end
    end else if (!hold) begin
      n.rem = m.rem - 9'd1;
      if (n.rem == 9'd0) begin
        n.rel[m.ch] = 1'b1;
        if (int'(m.ch) == nch - 1) begin
          n.busy = 1'b0;
          n.done = 1'b1;
        end else begin
          n.ch  = m.ch + 3'd1;
          n.rem = 9'(m.d[n.ch]) + 9'd1;
        end
      end
    end
    return n;
  endfunction

  mdl_t m_a = '0, m_b = '0, m_c = '0;

  always @(posedge clk) begin
    cyc <= cyc + 1;
    m_a <= mdl_step(m_a, 4, rst_a, start_a, hold_a, dv_a);
    m_b <= mdl_step(m_b, 4, rst_b, start_b, hold_b, dv_b);
    m_c <= mdl_step(m_c, 1, rst_c, start_c, hold_c, dv_c);
  end

  task automatic cmp(string nm, logic [5:0] act, logic [5:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s cyc=%0d got {rel,busy,done}=%b expected %b", nm, cyc, act, exp);
    end
  endtask

  always @(negedge clk) begin
    if (chk_on) begin
      cmp("model_a", {rel_a, busy_a, done_a}, {m_a.rel, m_a.busy, m_a.done});
      cmp("model_b", {rel_b, busy_b, done_b}, {m_b.rel, m_b.busy, m_b.done});
      cmp("model_c", {3'b000, rel_c, busy_c, done_c}, {3'b000, m_c.rel[0], m_c.busy, m_c.done});
    end
  end

  always @(posedge clk) begin
    if (cyc > 3000) begin
      $display("FAIL watchdog cyc=%0d expected finish before 3000", cyc);
      $fatal(1, "watchdog");
    end
  end

  // Pin both the DUT and the model to a hand-computed literal.
  task automatic pin(string nm, logic [5:0] dut, logic [5:0] mdl, logic [5:0] lit);
    cmp({nm, "_dut"}, dut, lit);
    cmp({nm, "_mdl"}, mdl, lit);
  endtask

  function automatic logic [5:0] pk_a();
    return {rel_a, busy_a, done_a};
  endfunction
  function automatic logic [5:0] pm_a();
    return {m_a.rel, m_a.busy, m_a.done};
  endfunction
  function automatic logic [5:0] pk_b();
    return {rel_b, busy_b, done_b};
  endfunction
  function automatic logic [5:0] pm_b();
    return {m_b.rel, m_b.busy, m_b.done};
  endfunction

  task automatic goto(int t);
    while (cyc < t) @(negedge clk);
  endtask

  // Pulse start across one edge; e0 is the cycle count after the accepting edge.
  task automatic start_pulse(int which, logic with_hold, output int e0);
    @(negedge clk);
    e0 = cyc + 1;
    case (which)
      0: start_a = 1'b1;
      1: start_b = 1'b1;
      default: begin start_c = 1'b1; hold_c = with_hold; end
    endcase
    @(negedge clk);
    start_a = 1'b0; start_b = 1'b0; start_c = 1'b0; hold_c = 1'b0;
  endtask

  initial begin
    int e0;
    repeat (2) @(negedge clk);
    rst_a = 1'b0; rst_b = 1'b0; rst_c = 1'b0;
    chk_on = 1'b1;
    pin("reset_a", pk_a(), pm_a(), 6'b000000);
    pin("reset_c", {3'b000, rel_c, busy_c, done_c}, {3'b000, m_c.rel[0], m_c.busy, m_c.done}, 6'b000000);

    // Basic sequence
    dv_a = {8'd2, 8'd5, 8'd0, 8'd3};
    start_pulse(0, 1'b0, e0);
    pin("basic_e0",  pk_a(), pm_a(), 6'b000010);
    goto(e0 + 3);  pin("basic_e3",  pk_a(), pm_a(), 6'b000010);
    goto(e0 + 4);  pin("basic_e4",  pk_a(), pm_a(), 6'b000110);
    goto(e0 + 5);  pin("basic_e5",  pk_a(), pm_a(), 6'b001110);
    goto(e0 + 10); pin("basic_e10", pk_a(), pm_a(), 6'b001110);
    goto(e0 + 11); pin("basic_e11", pk_a(), pm_a(), 6'b011110);
    goto(e0 + 13); pin("basic_e13", pk_a(), pm_a(), 6'b011110);
    goto(e0 + 14); pin("basic_e14", pk_a(), pm_a(), 6'b111101);
    goto(e0 + 17); pin("done_hold", pk_a(), pm_a(), 6'b111101);

    // Hold for edges E0+2..E0+4, restarting from DONE
    start_pulse(0, 1'b0, e0);
    pin("restart_a", pk_a(), pm_a(), 6'b000010);
    goto(e0 + 1); hold_a = 1'b1;
    goto(e0 + 4); hold_a = 1'b0;
    goto(e0 + 6);  pin("hold_e6",  pk_a(), pm_a(), 6'b000010);
    goto(e0 + 7);  pin("hold_e7",  pk_a(), pm_a(), 6'b000110);
    goto(e0 + 8);  pin("hold_e8",  pk_a(), pm_a(), 6'b001110);
    goto(e0 + 14); pin("hold_e14", pk_a(), pm_a(), 6'b011110);
    goto(e0 + 16); pin("hold_e16", pk_a(), pm_a(), 6'b011110);
    goto(e0 + 17); pin("hold_e17", pk_a(), pm_a(), 6'b111101);

    // Start pulse and live delay change during COUNT are ignored
    start_pulse(0, 1'b0, e0);
    goto(e0 + 1); dv_a = {4{8'hFF}}; start_a = 1'b1;
    goto(e0 + 2); start_a = 1'b0;
    goto(e0 + 4);  pin("ign_e4",  pk_a(), pm_a(), 6'b000110);
    goto(e0 + 13); pin("ign_e13", pk_a(), pm_a(), 6'b011110);
    goto(e0 + 14); pin("ign_e14", pk_a(), pm_a(), 6'b111101);

    // Reset mid-sequence wins and stops all further releases
    dv_a = {8'd2, 8'd5, 8'd0, 8'd3};
    start_pulse(0, 1'b0, e0);
    goto(e0 + 3); rst_a = 1'b1;
    goto(e0 + 4); rst_a = 1'b0;
    pin("rst_mid", pk_a(), pm_a(), 6'b000000);
    goto(e0 + 24); pin("rst_quiet", pk_a(), pm_a(), 6'b000000);

    // Max delay, narrow counter, then restart from DONE
    dv_b = {4{8'd15}};
    start_pulse(1, 1'b0, e0);
    goto(e0 + 15); pin("max_e15", pk_b(), pm_b(), 6'b000010);
    goto(e0 + 16); pin("max_e16", pk_b(), pm_b(), 6'b000110);
    goto(e0 + 32); pin("max_e32", pk_b(), pm_b(), 6'b001110);
    goto(e0 + 48); pin("max_e48", pk_b(), pm_b(), 6'b011110);
    goto(e0 + 63); pin("max_e63", pk_b(), pm_b(), 6'b011110);
    goto(e0 + 64); pin("max_e64", pk_b(), pm_b(), 6'b111101);
    start_pulse(1, 1'b0, e0);
    pin("max_re_e0",  pk_b(), pm_b(), 6'b000010);
    goto(e0 + 16); pin("max_re_e16", pk_b(), pm_b(), 6'b000110);
    goto(e0 + 64); pin("max_re_e64", pk_b(), pm_b(), 6'b111101);

    // Single channel, zero delay, start together with hold
    dv_c = '0;
    start_pulse(2, 1'b1, e0);
    pin("one_e0", {3'b000, rel_c, busy_c, done_c}, {3'b000, m_c.rel[0], m_c.busy, m_c.done}, 6'b000010);
    goto(e0 + 1);
    pin("one_e1", {3'b000, rel_c, busy_c, done_c}, {3'b000, m_c.rel[0], m_c.busy, m_c.done}, 6'b000101);

    repeat (3) @(negedge clk);
    chk_on = 1'b0;
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/delay_seq.md
# delay_seq

Parametrised multi-channel release sequencer for the clock/reset generation area. On a start request it releases NUM_CH outputs one after another, each after its own programmable delay counted from the previous release, then flags completion. Used to stage reset deassertion and enables across downstream domains that sit on the same clock. Supports pause, restart and a runtime per-channel delay.

## Interface
- NUM_CH, default 4: number of sequenced channels, ≥1.
- DELAY_W, default 8: width of each per-channel delay value, ≥1.

- clk_i  input  1  clock, all logic on rising edge.
- rst_i  input  1  synchronous reset, active-high, sampled on clk_i rising edge.
- start_i  input  1  start request; accepted only in IDLE or DONE.
- hold_i  input  1  pause; freezes counting while in COUNT.
- delay_i  input  NUM_CH*DELAY_W  flattened delays, channel k at bits [k*DELAY_W +: DELAY_W].
- release_o  output  NUM_CH  sticky per-channel release, channel 0 first.
- busy_o  output  1  high while in COUNT.
- done_o  output  1  high in DONE, after all channels released.

## Operation
- States: IDLE, COUNT, DONE. Registers: cnt (DELAY_W bits), ch index ($clog2(NUM_CH) bits, min 1), dly_q (latched copy of delay_i), release_o, state.
- Reset (rst_i high at an edge): state IDLE, cnt 0, ch 0, release_o all 0, busy_o 0, done_o 0; dly_q 0. Reset wins over every other input, including mid-sequence.
- IDLE, start_i high: latch delay_i into dly_q, cnt←0, ch←0, release_o←0, go COUNT. hold_i at the same edge is ignored.
- DONE, start_i high: identical to IDLE start; release_o and done_o clear at that edge (restart). DONE without start_i: hold everything.
- COUNT, hold_i high: cnt, ch, release_o unchanged. start_i ignored.
- COUNT, hold_i low:
  - cnt == dly_q[ch]: release_o[ch]←1, cnt←0; if ch == NUM_CH-1 go DONE, else ch←ch+1.
  - otherwise cnt←cnt+1.
- delay_i changes during COUNT have no effect; only dly_q is used.
- No wrap of cnt is possible: cnt never exceeds dly_q[ch] ≤ 2^DELAY_W-1.
- release_o bits only set, never clear, except by start acceptance or reset; bit k never sets before bit k-1.
- busy_o = (state == COUNT); done_o = (state == DONE); both registered-state decodes, no combinational path from inputs.

## Timing
- Start accepted at edge E0. Channel 0 rises at edge E0 + d0 + 1 (d = latched delay, no hold). Delay 0 → release one cycle after start.
- Channel k rises d_k + 1 cycles after channel k-1.
- done_o rises at the same edge as release_o[NUM_CH-1]; busy_o falls at that edge.
- Total unheld latency start→done: sum over k of (d_k + 1) cycles.
- Each cycle with hold_i high in COUNT adds exactly one cycle to the pending release.
- Restart from DONE: release_o all 0 and busy_o 1 from edge E0; first release d0+1 cycles later.

## Structure
- delay_seq_pkg: state enum (IDLE, COUNT, DONE) and a helper localparam function for channel-index width (max(1, $clog2(NUM_CH))).
- One sub-module is natural: seq_counter, a DELAY_W-bit counter with clear, enable and terminal-compare against a loaded value, producing a registered-free terminal flag; delay_seq instantiates it once and owns state, ch and release_o.

## Test plan
- Reset mid-sequence: NUM_CH=4, delays {3,0,5,2}, start, assert rst_i 4 cycles later → next edge release_o=0, busy_o=0, done_o=0, state IDLE; no further releases.
- Basic sequence: delays ch0..3 = {3,0,5,2}, start at E0 → release_o[0] at E0+4, [1] at E0+5, [2] at E0+11, [3] and done_o at E0+14; busy_o high E0..E0+13.
- Hold: same delays, hold_i high for 3 cycles starting E0+2 → release_o[0] at E0+7, all later releases shifted by 3, done_o at E0+17.
- Ignored start and live delay change: during COUNT pulse start_i and change delay_i to all 0xFF → timing identical to basic sequence.
- Max delay and restart: DELAY_W=4, all delays 15, start → each channel 16 cycles apart, done_o at E0+64; start in DONE → release_o and done_o clear at that edge, sequence repeats identically.
- NUM_CH=1, delay 0: start at E0 → release_o[0] and done_o at E0+1; start in IDLE together with hold_i → start accepted.
